// File: rtl/timer_slot_sequencer.sv
// rtl/timer_slot_sequencer.sv - round-robin time-slot sequencer that programs one interval timer over Avalon-MM
// Optional feature macro SLOT_OVERRUN_EN: counts slots that time out before the core reports slot_done.
`timescale 1ns/1ps
module timer_slot_sequencer #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cfg_address,
  input  logic              cfg_chipselect,
  input  logic              cfg_write_n,
  input  logic [31:0]       cfg_writedata,
  output logic [31:0]       cfg_readdata,
  output logic [8:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [31:0]       tmr_writedata,
  input  logic              tmr_irq,
  input  logic              slot_done,
  output logic [SLOT_W-1:0] cur_slot,
  output logic              slot_start,
  output logic              slot_end
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_RUN, S_ACK, S_STOP
  } state_t;

  state_t            state, state_nx;
  logic [31:0]       table_q [8];
  logic [31:0]       period_q;
  logic [31:0]       tbl_sel;
  logic [31:0]       rd_mux;
  logic [15:0]       overrun_q;
  logic [SLOT_W-1:0] cur_slot_nx;
  logic [2:0]        slot_idx;
  logic              enable_q, enable_nx;
  logic              cfg_wr, cfg_rd, tbl_hit;

  assign cfg_wr    = cfg_chipselect && !cfg_write_n;
  assign cfg_rd    = cfg_chipselect && cfg_write_n;
  assign tbl_hit   = cfg_address[3] && ({29'd0, cfg_address[2:0]} < 32'(NUM_SLOTS));
  assign enable_nx = (cfg_wr && cfg_address == 4'd0) ? cfg_writedata[0] : enable_q;
  assign slot_idx  = 3'(cur_slot_nx);
  assign tbl_sel   = table_q[slot_idx];

  // Disable is seen in the cycle the CTRL write arrives; IDLE also needs the
  // registered bit so a set immediately followed by a clear issues nothing.
  always_comb begin
    state_nx       = state;
    cur_slot_nx    = cur_slot;
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = '0;
    tmr_writedata  = '0;
    slot_start     = 1'b0;
    slot_end       = 1'b0;
    case (state)
      S_IDLE: if (enable_q && enable_nx) state_nx = S_WR_PL;
      S_WR_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 9'd2;
        tmr_writedata  = {16'd0, period_q[15:0]};
        state_nx       = enable_nx ? S_WR_PH : S_STOP;
      end
      S_WR_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 9'd3;
        tmr_writedata  = {16'd0, period_q[31:16]};
        state_nx       = enable_nx ? S_WR_CTRL : S_STOP;
      end
      S_WR_CTRL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 9'd1;
        tmr_writedata  = 32'h7;
        slot_start     = 1'b1;
        state_nx       = enable_nx ? S_RUN : S_STOP;
      end
      S_RUN: begin
        if (!enable_nx)   state_nx = S_STOP;
        else if (tmr_irq) state_nx = S_ACK;
      end
      S_ACK: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 9'd0;
        tmr_writedata  = 32'h0;
        slot_end       = 1'b1;
        cur_slot_nx    = (cur_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : cur_slot + SLOT_W'(1);
        state_nx       = enable_nx ? S_WR_PL : S_STOP;
      end
      S_STOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 9'd1;
        tmr_writedata  = 32'h8;
        cur_slot_nx    = '0;
        state_nx       = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cur_slot <= '0;
      period_q <= '0;
      enable_q <= 1'b0;
    end else begin
      state    <= state_nx;
      cur_slot <= cur_slot_nx;
      enable_q <= enable_nx;
      // One snapshot per slot keeps both period halves consistent.
      if (state_nx == S_WR_PL)
        period_q <= (tbl_sel == 32'd0) ? 32'd1 : tbl_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) table_q[i] <= '0;
    end else if (cfg_wr && tbl_hit) begin
      table_q[cfg_address[2:0]] <= cfg_writedata;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (tbl_hit) begin
      rd_mux = table_q[cfg_address[2:0]];
    end else begin
      case (cfg_address)
        4'd0:    rd_mux[0]        = enable_q;
        4'd1:    rd_mux[SLOT_W:0] = {state != S_IDLE, cur_slot};
        4'd2:    rd_mux[15:0]     = overrun_q;
        default: rd_mux           = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cfg_readdata <= '0;
    else if (cfg_rd) cfg_readdata <= rd_mux;
  end

`ifdef SLOT_OVERRUN_EN
  logic done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q    <= 1'b0;
      overrun_q <= '0;
    end else begin
      if (state == S_WR_CTRL)              done_q <= 1'b0;
      else if (state == S_RUN && slot_done) done_q <= 1'b1;
      if (cfg_wr && cfg_address == 4'd2)
        overrun_q <= '0;
      else if (state == S_RUN && state_nx == S_ACK && !done_q && overrun_q != 16'hFFFF)
        overrun_q <= overrun_q + 16'd1;
    end
  end
`else
  logic unused_slot_done;
  assign unused_slot_done = slot_done;
  assign overrun_q        = '0;
`endif

endmodule
